message_receive: RTL and testbench

MESSAGE_RECEIVE -- requirements
Module: message_receive

---
 rtl/message_receive.sv | 191 +++++++++++++++++++
 tb/tb_message_receive.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/message_receive.sv
// Serial frame receiver: waits out a quiet line, locks onto the header edge,
// mid-bit samples a fixed 4-bit header plus a 5-bit payload, reports result.
module message_receive #(
    parameter int unsigned BIT_PERIOD = 1024,
    parameter logic [3:0]  HEADER     = 4'b0101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       msg_bit,
    output logic [4:0] msg,
    output logic       msg_valid,
    output logic       hdr_err,
    output logic       busy
);

    localparam int unsigned CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(BIT_PERIOD / 2 - 1);

    typedef enum logic [1:0] {ARM, HUNT, RX, DONE} state_e;

    state_e        state_q, state_d;
    logic          sync_q, line_q, line_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [4:0]    payload_q, payload_d;
    logic [4:0]    msg_q, msg_d;
    logic          msg_valid_q, msg_valid_d;
    logic          hdr_err_q, hdr_err_d;
    logic          busy_q, busy_d;

    logic          sample_c;
    logic          edge_c;
    logic          hdr_bit_c;
    logic          in_hdr_c;
    logic          hdr_ok_c;

    assign sample_c = (state_q == RX) && (cnt_q == CNT_MID);
    assign edge_c   = line_q && !line_prev_q;
    assign in_hdr_c = (bit_idx_q >= 4'd1) && (bit_idx_q <= 4'd3);
    assign hdr_ok_c = (line_q == hdr_bit_c);

    // Header bit expected at the current bit index (HEADER[3] is the implied quiet bit).
    always_comb begin
        hdr_bit_c = 1'b0;
        case (bit_idx_q)
            4'd1:    hdr_bit_c = HEADER[2];
            4'd2:    hdr_bit_c = HEADER[1];
            4'd3:    hdr_bit_c = HEADER[0];
            default: hdr_bit_c = 1'b0;
        endcase
    end

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 1'b0;
            line_q      <= 1'b0;
            line_prev_q <= 1'b0;
        end else begin
            sync_q      <= msg_bit;
            line_q      <= sync_q;
            line_prev_q <= line_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM: begin
                if (!line_q && (cnt_q == CNT_LAST)) begin
                    state_d = HUNT;
                end
            end
            HUNT: begin
                if (edge_c) begin
                    state_d = RX;
                end
            end
            RX: begin
                if (sample_c) begin
                    if (in_hdr_c && !hdr_ok_c) begin
                        state_d = ARM;
                    end else if (bit_idx_q == 4'd8) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = ARM;
            end
            default: begin
                state_d = ARM;
            end
        endcase
    end

    // Counters, payload shifting and the registered result pulses.
    always_comb begin
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        payload_d   = payload_q;
        msg_d       = msg_q;
        msg_valid_d = 1'b0;
        hdr_err_d   = 1'b0;
        busy_d      = (state_d == RX) || (state_d == DONE);
        case (state_q)
            ARM: begin
                if (line_q || (cnt_q == CNT_LAST)) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                bit_idx_d = 4'd0;
            end
            HUNT: begin
                cnt_d = '0;
                if (edge_c) begin
                    bit_idx_d = 4'd1;
                    payload_d = 5'd0;
                end
            end
            RX: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (sample_c) begin
                    if (in_hdr_c) begin
                        if (!hdr_ok_c) begin
                            hdr_err_d = 1'b1;
                            cnt_d     = '0;
                            bit_idx_d = 4'd0;
                        end
                    end else begin
                        payload_d = {payload_q[3:0], line_q};
                        if (bit_idx_q == 4'd8) begin
                            msg_d       = {payload_q[3:0], line_q};
                            msg_valid_d = 1'b1;
                            cnt_d       = '0;
                        end
                    end
                end
            end
            DONE: begin
                cnt_d     = '0;
                bit_idx_d = 4'd0;
            end
            default: begin
                cnt_d     = '0;
                bit_idx_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            bit_idx_q   <= 4'd0;
            payload_q   <= 5'd0;
            msg_q       <= 5'd0;
            msg_valid_q <= 1'b0;
            hdr_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            payload_q   <= payload_d;
            msg_q       <= msg_d;
            msg_valid_q <= msg_valid_d;
            hdr_err_q   <= hdr_err_d;
            busy_q      <= busy_d;
        end
    end

    assign msg       = msg_q;
    assign msg_valid = msg_valid_q;
    assign hdr_err   = hdr_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_message_receive.sv
// Bench for message_receive: waveform segments scored against a frame-level
// model that scans the synchronized line for quiet periods, edges and mid-bit samples.
module tb_message_receive;

    localparam int unsigned BP   = 16;
    localparam logic [3:0]  HDR  = 4'b0101;
    localparam int          MAXC = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       msg_bit = 1'b0;
    logic [4:0] msg;
    logic       msg_valid;
    logic       hdr_err;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;

    bit         wq[$];
    bit         ln_a[MAXC];
    bit         ev_v[MAXC];
    bit         ev_e[MAXC];
    bit         ev_b[MAXC];
    logic [4:0] pv[MAXC];
    logic [4:0] ev_m[MAXC];

    message_receive #(.BIT_PERIOD(BP), .HEADER(HDR)) dut (
        .clk       (clk),
        .rst       (rst),
        .msg_bit   (msg_bit),
        .msg       (msg),
        .msg_valid (msg_valid),
        .hdr_err   (hdr_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_lvl(input bit b, input int n);
        repeat (n) wq.push_back(b);
    endtask

    task automatic push_frame(input logic [3:0] h, input logic [4:0] p);
        logic [8:0] f;
        f = {h, p};
        for (int i = 8; i >= 0; i--) push_lvl(f[i], BP);
    endtask

    // Line seen by the receiver lags the driven bit by two clocks; a frame is
    // BP quiet cycles, a rising edge, then samples half a bit after each bit start.
    task automatic build_model();
        int a, c, h, e, s, v, run;
        bit ok, trunc;
        logic [4:0] pay, cur;
        logic [3:0] hv;
        hv = HDR;
        for (int i = 0; i < MAXC; i++) begin
            ln_a[i] = (i >= 2 && (i - 2) < wq.size()) ? wq[i-2] : 1'b0;
            ev_v[i] = 1'b0;
            ev_e[i] = 1'b0;
            ev_b[i] = 1'b0;
            pv[i]   = 5'd0;
        end
        a = 0;
        while (a < MAXC - 1) begin
            h = -1;
            run = 0;
            for (c = a; c < MAXC; c++) begin
                run = ln_a[c] ? 0 : run + 1;
                if (run == BP) begin
                    h = c + 1;
                    break;
                end
            end
            if (h < 0 || h >= MAXC) break;
            e = -1;
            for (c = h; c < MAXC; c++) begin
                if (ln_a[c] && !ln_a[c-1]) begin
                    e = c;
                    break;
                end
            end
            if (e < 0) break;
            ok = 1'b1;
            trunc = 1'b0;
            pay = 5'd0;
            s = e;
            for (int k = 1; k <= 8; k++) begin
                s = e + (k - 1) * BP + BP / 2;
                if (s + 1 >= MAXC) begin
                    trunc = 1'b1;
                    break;
                end
                if (k <= 3 && ln_a[s] != hv[3-k]) begin
                    ok = 1'b0;
                    break;
                end
                if (k >= 4) pay = {pay[3:0], ln_a[s]};
            end
            if (trunc) break;
            v = s + 1;
            for (c = e + 1; c < (ok ? v + 1 : v); c++) ev_b[c] = 1'b1;
            if (ok) begin
                ev_v[v] = 1'b1;
                pv[v]   = pay;
                a       = v + 1;
            end else begin
                ev_e[v] = 1'b1;
                a       = v;
            end
        end
        cur = 5'd0;
        for (int i = 0; i < MAXC; i++) begin
            if (ev_v[i]) cur = pv[i];
            ev_m[i] = cur;
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_msg"},   int'(msg),       0);
        check_val({tag, "_valid"}, int'(msg_valid), 0);
        check_val({tag, "_err"},   int'(hdr_err),   0);
        check_val({tag, "_busy"},  int'(busy),      0);
    endtask

    // Reset, play the queued waveform, score every cycle; optional reset mid-run.
    task automatic run_segment(input string name, input int rst_at);
        int n_cyc;
        n_cyc = wq.size();
        if (n_cyc > MAXC - 4) n_cyc = MAXC - 4;
        @(negedge clk);
        rst = 1'b1;
        msg_bit = 1'b0;
        #1;
        check_zero({name, "_rst"});
        build_model();
        @(negedge clk);
        rst = 1'b0;
        msg_bit = wq[0];
        for (int n = 1; n <= n_cyc; n++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("%s_valid@%0d", name, n), int'(msg_valid), int'(ev_v[n]));
            check_val($sformatf("%s_err@%0d", name, n),   int'(hdr_err),   int'(ev_e[n]));
            check_val($sformatf("%s_busy@%0d", name, n),  int'(busy),      int'(ev_b[n]));
            check_val($sformatf("%s_msg@%0d", name, n),   int'(msg),       int'(ev_m[n]));
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                check_zero({name, "_midrst"});
                break;
            end
            @(negedge clk);
            if (n < n_cyc) msg_bit = wq[n];
        end
        wq.delete();
    endtask

    initial begin
        int f2;
        logic [8:0] fb;
        logic [3:0] h;

        push_lvl(0, 40); push_frame(HDR, 5'b10110); push_lvl(0, 40);
        run_segment("basic", 0);

        push_lvl(0, 40); push_frame(4'b0111, 5'b00001); push_lvl(0, 40);
        run_segment("badhdr", 0);

        push_lvl(0, 40); push_lvl(1, 3); push_lvl(0, 150);
        run_segment("glitch", 0);

        push_lvl(0, 40); push_frame(HDR, 5'b11111); push_lvl(1, 16); push_lvl(0, 8);
        fb = {HDR, 5'b00000};
        for (int i = 7; i >= 0; i--) push_lvl(fb[i], BP);
        push_lvl(0, 60);
        run_segment("b2b", 0);

        push_lvl(0, 40); push_frame(HDR, 5'b01010); push_lvl(0, 20);
        push_frame(HDR, 5'b10101); push_lvl(0, 40);
        run_segment("two", 0);

        push_lvl(0, 40); push_frame(HDR, 5'b11011); push_lvl(0, 20);
        f2 = wq.size();
        push_frame(HDR, 5'b10101); push_lvl(0, 40);
        run_segment("midrst", f2 + 6 * BP + BP / 2 + 2);

        push_lvl(0, 30); push_frame(HDR, 5'b01101); push_lvl(0, 40);
        run_segment("after", 0);

        for (int seg = 0; seg < 6; seg++) begin
            push_lvl(0, $urandom_range(16, 40));
            for (int f = 0; f < 3; f++) begin
                case ($urandom_range(0, 4))
                    0: begin
                        h = {1'b0, 3'($urandom_range(0, 7))};
                        push_frame(h, 5'($urandom_range(0, 31)));
                    end
                    1: begin
                        repeat ($urandom_range(1, 6)) push_lvl(1'($urandom_range(0, 1)), $urandom_range(1, 6));
                    end
                    default: push_frame(HDR, 5'($urandom_range(0, 31)));
                endcase
                push_lvl(0, $urandom_range(0, 30));
            end
            push_lvl(0, 40);
            run_segment($sformatf("rnd%0d", seg), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
